// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto a single-cycle synchronous memory port.
// Define FAIR_ARB_EN to enable the fetch starvation guard.
module mem_port_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic              dm_byte,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall
);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_LOAD_W,
      OWN_LOAD_B
   } owner_e;

   owner_e     owner_q, owner_d;
   logic [1:0] off_q, off_d;
   logic       fetch_first;
   logic       unused_addr;

   assign unused_addr = ^if_addr[1:0];

`ifdef FAIR_ARB_EN
   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_q, starve_d;

   assign fetch_first = (starve_q == CW'(STARVE_MAX));

   always_comb begin
      starve_d = starve_q;
      if (!if_req || if_gnt)
         starve_d = '0;
      else if (starve_q != CW'(STARVE_MAX))
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         starve_q <= '0;
      else
         starve_q <= starve_d;
   end
`else
   assign fetch_first = 1'b0;
`endif

   assign if_gnt = rst_n & if_req & (~dm_req | fetch_first);
   assign dm_gnt = rst_n & dm_req & ~if_gnt;
   assign stall  = (if_req & ~if_gnt) | (dm_req & ~dm_gnt);

   always_comb begin
      mem_en    = if_gnt | dm_gnt;
      mem_we    = dm_gnt & dm_we;
      mem_be    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_be   = 4'b1111;
         mem_addr = if_addr[ADDR_W-1:2];
      end else if (dm_gnt) begin
         mem_be   = 4'b1111;
         mem_addr = dm_addr[ADDR_W-1:2];
         if (dm_we) begin
            mem_wdata = dm_wdata;
            // Byte stores replicate the byte so any lane picks it up.
            if (dm_byte) begin
               mem_be    = 4'b0001 << dm_addr[1:0];
               mem_wdata = {(DATA_W/8){dm_wdata[7:0]}};
            end
         end
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      off_d   = dm_addr[1:0];
      if (if_gnt)
         owner_d = OWN_FETCH;
      else if (dm_gnt && !dm_we)
         owner_d = dm_byte ? OWN_LOAD_B : OWN_LOAD_W;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q <= OWN_NONE;
         off_q   <= 2'b00;
      end else begin
         owner_q <= owner_d;
         off_q   <= off_d;
      end
   end

   assign if_rvalid = (owner_q == OWN_FETCH);
   assign dm_rvalid = (owner_q == OWN_LOAD_W) | (owner_q == OWN_LOAD_B);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;

   always_comb begin
      dm_rdata = '0;
      if (owner_q == OWN_LOAD_W)
         dm_rdata = mem_rdata;
      else if (owner_q == OWN_LOAD_B)
         dm_rdata[7:0] = mem_rdata[8*off_q +: 8];
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, corner sequences,
// then randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_byte, dm_gnt, dm_rvalid;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_en, mem_we, stall;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   int m_kind = 0;
   int m_off  = 0;
   int m_den  = 0;
   logic m_ig, m_dg;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
      .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall(stall)
   );

   typedef struct packed {
      logic         rst;
      logic         ir;
      logic [31:0]  ia;
      logic         dr, dw, db;
      logic [31:0]  da, dd, rd;
      logic [136:0] exp;
   } vec_t;

   vec_t tbl [15];

   function automatic logic [136:0] ex(
      input logic ig, dg, en, we, input logic [3:0] be,
      input logic [29:0] a, input logic [31:0] wd,
      input logic st, iv, dv, input logic [31:0] id, dd);
      return {ig, dg, en, we, be, a, wd, st, iv, dv, id, dd};
   endfunction

   function automatic vec_t v(
      input logic rst, ir, input logic [31:0] ia,
      input logic dr, dw, db, input logic [31:0] da, dd, rd,
      input logic [136:0] e);
      return '{rst:rst, ir:ir, ia:ia, dr:dr, dw:dw, db:db,
               da:da, dd:dd, rd:rd, exp:e};
   endfunction

   function automatic logic [136:0] act();
      return {if_gnt, dm_gnt, mem_en, mem_we, mem_be, mem_addr,
              mem_wdata, stall, if_rvalid, dm_rvalid, if_rdata,
              dm_rdata};
   endfunction

   task automatic cmp(input string nm, input logic [136:0] a,
                      input logic [136:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   task automatic model_grant();
      bit fair;
      fair = 1'b0;
`ifdef FAIR_ARB_EN
      fair = (m_den >= SM);
`endif
      m_ig = 1'b0;
      m_dg = 1'b0;
      if (rst_n) begin
         if (if_req && dm_req) begin
            m_ig = fair;
            m_dg = !fair;
         end else begin
            m_ig = if_req;
            m_dg = dm_req;
         end
      end
   endtask

   function automatic logic [136:0] model_out();
      logic en, we, st, iv, dv;
      logic [3:0] be;
      logic [29:0] a;
      logic [31:0] wd, id, dd;
      en = m_ig | m_dg;
      we = m_dg && dm_we;
      be = 4'h0;
      a  = '0;
      wd = '0;
      if (m_ig) begin
         be = 4'hF;
         a  = if_addr / 4;
      end else if (m_dg) begin
         a  = dm_addr / 4;
         be = (dm_we && dm_byte) ? 4'(1 << (dm_addr % 4)) : 4'hF;
         if (dm_we)
            wd = dm_byte ? 32'(dm_wdata[7:0]) * 32'h01010101
                         : dm_wdata;
      end
      st = (if_req && !m_ig) || (dm_req && !m_dg);
      iv = (m_kind == 1);
      dv = (m_kind == 2) || (m_kind == 3);
      id = iv ? mem_rdata : 32'h0;
      dd = 32'h0;
      if (m_kind == 2) dd = mem_rdata;
      if (m_kind == 3) dd = (mem_rdata >> (8 * m_off)) & 32'hFF;
      return {m_ig, m_dg, en, we, be, a, wd, st, iv, dv, id, dd};
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         m_kind = 0;
         m_den  = 0;
      end else begin
         m_kind = m_ig ? 1 : (m_dg && !dm_we) ? (dm_byte ? 3 : 2) : 0;
         m_off  = int'(dm_addr % 4);
         if (if_req && !m_ig)
            m_den = (m_den < SM) ? m_den + 1 : m_den;
         else
            m_den = 0;
      end
   endtask

   task automatic idle();
      if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
      dm_byte = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
   endtask

   initial begin
      logic [2:0] e3;
      logic [136:0] a;

      tbl[0]  = v(0,0,0,0,0,0,0,0,0, ex(0,0,0,0,0,0,0,0,0,0,0,0));
      tbl[1]  = v(0,0,0,0,0,0,0,0,0, ex(0,0,0,0,0,0,0,0,0,0,0,0));
      tbl[2]  = v(1,1,32'h10,0,0,0,0,0,0,
                  ex(1,0,1,0,4'hF,30'h4,0,0,0,0,0,0));
      tbl[3]  = v(1,0,0,0,0,0,0,0,32'hCAFEF00D,
                  ex(0,0,0,0,0,0,0,0,1,0,32'hCAFEF00D,0));
      tbl[4]  = v(1,1,32'h20,1,0,0,32'h40,0,0,
                  ex(0,1,1,0,4'hF,30'h10,0,1,0,0,0,0));
      tbl[5]  = v(1,1,32'h20,0,0,0,0,0,32'h11112222,
                  ex(1,0,1,0,4'hF,30'h8,0,0,0,1,0,32'h11112222));
      tbl[6]  = v(1,0,0,0,0,0,0,0,32'h33334444,
                  ex(0,0,0,0,0,0,0,0,1,0,32'h33334444,0));
      tbl[7]  = v(1,0,0,1,1,1,32'h7,32'hAB,0,
                  ex(0,1,1,1,4'h8,30'h1,32'hABABABAB,0,0,0,0,0));
      tbl[8]  = v(1,0,0,0,0,0,0,0,32'h55555555,
                  ex(0,0,0,0,0,0,0,0,0,0,0,0));
      tbl[9]  = v(1,0,0,1,0,1,32'h3,0,0,
                  ex(0,1,1,0,4'hF,30'h0,0,0,0,0,0,0));
      tbl[10] = v(1,0,0,0,0,0,0,0,32'h12345678,
                  ex(0,0,0,0,0,0,0,0,0,1,0,32'h12));
      tbl[11] = v(1,0,0,1,1,0,32'h8,32'hDEADBEEF,0,
                  ex(0,1,1,1,4'hF,30'h2,32'hDEADBEEF,0,0,0,0,0));
      tbl[12] = v(1,0,0,1,0,0,32'hC,0,0,
                  ex(0,1,1,0,4'hF,30'h3,0,0,0,0,0,0));
      tbl[13] = v(0,0,0,1,0,0,32'hC,0,32'h77778888,
                  ex(0,0,0,0,0,0,0,1,0,1,0,32'h77778888));
      tbl[14] = v(1,0,0,0,0,0,0,0,32'h99,
                  ex(0,0,0,0,0,0,0,0,0,0,0,0));

      rst_n = 0;
      idle();
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         rst_n = tbl[i].rst; if_req = tbl[i].ir; if_addr = tbl[i].ia;
         dm_req = tbl[i].dr; dm_we = tbl[i].dw; dm_byte = tbl[i].db;
         dm_addr = tbl[i].da; dm_wdata = tbl[i].dd;
         mem_rdata = tbl[i].rd;
         #1;
         model_grant();
         cmp($sformatf("vec%0d", i), act(), tbl[i].exp);
         model_step();
         @(negedge clk);
      end

      // Both ports hammer the memory continuously.
      for (int c = 1; c <= 8; c++) begin
         rst_n = 1; idle();
         if_req = 1; if_addr = 32'h200;
         dm_req = 1; dm_addr = 32'h100;
         #1;
         e3 = 3'b011;
`ifdef FAIR_ARB_EN
         if (c == SM + 1) e3 = 3'b101;
`endif
         n_cmp++;
         if ({if_gnt, dm_gnt, stall} !== e3) begin
            n_bad++;
            $display("FAIL contend%0d: got %b want %b", c,
                     {if_gnt, dm_gnt, stall}, e3);
         end
         model_grant();
         model_step();
         @(negedge clk);
      end
      idle();
      #1;
      model_grant();
      model_step();
      @(negedge clk);

      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(0, 19) != 0);
         if (!(if_req && !m_ig)) begin
            if_req  = $urandom_range(0, 2) != 0;
            if_addr = $urandom;
         end
         if (!(dm_req && !m_dg)) begin
            dm_req   = $urandom_range(0, 1);
            dm_we    = $urandom_range(0, 1);
            dm_byte  = $urandom_range(0, 1);
            dm_addr  = $urandom;
            dm_wdata = $urandom;
         end
         mem_rdata = $urandom;
         #1;
         model_grant();
         a = act();
         cmp($sformatf("rand%0d", c), a, model_out());
         model_step();
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data width; ADDR_W, default 32, byte address width; STARVE_MAX, default 4, consecutive fetch denials before forced fetch grant.
REQ-002 Ports SHALL be, in this order: clk  in  1  single clock, rising edge; rst_n  in  1  synchronous reset, active-low.
REQ-003 Fetch ports SHALL be: if_req  in  1  fetch request; if_addr  in  ADDR_W  fetch byte address; if_gnt  out  1  fetch issued this cycle; if_rvalid  out  1  fetch data valid; if_rdata  out  DATA_W  fetch word.
REQ-004 Data ports SHALL be: dm_req  in  1  load/store request; dm_we  in  1  1=store; dm_byte  in  1  byte access (ByteEnable); dm_addr  in  ADDR_W  byte address; dm_wdata  in  DATA_W  store data; dm_gnt  out  1  issued; dm_rvalid  out  1  load data valid; dm_rdata  out  DATA_W  load data.
REQ-005 Memory ports SHALL be: mem_en  out  1  access strobe; mem_we  out  1  write; mem_be  out  4  byte lanes; mem_addr  out  ADDR_W-2  word address; mem_wdata  out  DATA_W  write data; mem_rdata  in  DATA_W  read data, valid one cycle after mem_en with mem_we=0.
REQ-006 Status port SHALL be: stall  out  1  a request is pending and not granted this cycle.

Function
REQ-007 Requests SHALL be level signals held with stable address and data until the matching gnt is sampled high.
REQ-008 At most one of if_gnt, dm_gnt SHALL be high per cycle; grants are combinational from the current requests and registered state.
REQ-009 Default priority SHALL be data over fetch; when only one port requests, that port is granted in the same cycle.
REQ-010 On grant, mem_en=1, mem_addr=addr[ADDR_W-1:2] of the granted port, and mem_we=dm_we for data and 0 for fetch.
REQ-011 Word store SHALL drive mem_be=4'b1111 and mem_wdata=dm_wdata.
REQ-012 Byte store SHALL drive mem_be=4'b0001<<dm_addr[1:0], with dm_wdata[7:0] replicated on all four lanes.
REQ-013 Fetch and load reads SHALL drive mem_be=4'b1111.
REQ-014 A registered response owner SHALL take one of NONE, FETCH, LOAD_W, LOAD_B.
REQ-015 The owner SHALL be written each cycle from the current grant; a store or no grant writes NONE.
REQ-016 For a LOAD_B owner, the registered byte offset SHALL also be written each cycle.
REQ-017 The cycle after a fetch grant, if_rvalid=1 and if_rdata=mem_rdata.
REQ-018 The cycle after a word load grant, dm_rvalid=1 and dm_rdata=mem_rdata.
REQ-019 The cycle after a byte load grant, dm_rvalid=1 and dm_rdata is mem_rdata byte[offset], zero-extended; offset 3 selects bits 31:24.
REQ-020 Read latency SHALL be exactly 1 cycle; back-to-back grants SHALL be supported with no bubble.
REQ-021 A store SHALL complete at grant and produce no rvalid.
REQ-022 When neither port is granted: mem_en=0, mem_we=0, mem_be=0.
REQ-023 stall SHALL equal (if_req & ~if_gnt) | (dm_req & ~dm_gnt).

Reset
REQ-024 While rst_n=0 at a clock edge: owner=NONE, starvation counter=0, and if_rvalid=dm_rvalid=0 the next cycle.
REQ-025 A read granted in the cycle reset is sampled low SHALL produce no rvalid.
REQ-026 While rst_n=0, all grants and mem_en SHALL be forced to 0.

Configuration
REQ-027 Macro FAIR_ARB_EN SHALL control the fetch starvation guard.
REQ-028 With FAIR_ARB_EN defined: a saturating counter increments each cycle if_req=1 and if_gnt=0, and clears on any cycle if_gnt=1 or if_req=0.
REQ-029 With FAIR_ARB_EN defined: when the counter equals STARVE_MAX, fetch wins over data for that one cycle, and data stalls.
REQ-030 Without FAIR_ARB_EN: strict data priority; the counter SHALL be absent.

Verification
REQ-031 if_req=1, if_addr=0x10 alone -> if_gnt=1, mem_addr=0x4, mem_en=1; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-032 if_req=dm_req=1, dm_we=0 -> dm_gnt=1, if_gnt=0, stall=1; next cycle dm_rvalid=1, then if_gnt=1.
REQ-033 Byte store dm_addr=0x7, dm_wdata=0xAB -> mem_be=4'b1000, mem_wdata=0xABABABAB, no dm_rvalid.
REQ-034 Byte load dm_addr=0x3 with mem_rdata=0x12345678 -> dm_rdata=0x00000012.
REQ-035 FAIR_ARB_EN, both ports requesting continuously -> fetch granted on cycle 5 (after 4 denials), then data resumes.
REQ-036 Load granted, rst_n=0 on next edge -> no dm_rvalid; all outputs 0 after reset.
